// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code controller.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Valid/ready stream carrying decoded key events from the controller to its consumer.
interface ps2_key_ctrl_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;

  modport master (output key_valid, key_code, key_ext, key_break, input key_ready);
  modport slave  (input key_valid, key_code, key_ext, key_break, output key_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous first-word fall-through FIFO for key events; a pop frees a slot for a
// push in the same cycle, so a full FIFO can accept both.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  ps2_evt_t din,
  output ps2_evt_t dout,
  output logic     empty,
  output logic     full,
  output logic     full_nxt
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  assign full_nxt = (count_nxt == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; empty gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {code, ext, break} events with a
// prefix watchdog. Define PS2_KEY_FIFO_EN to buffer events in a FIFO instead of one register.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_done_tick,
  input  logic [7:0]     rx_dout,
  output logic           rx_en,
  output logic           err_tick,
  ps2_key_ctrl_if.master key
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  ps2_state_e      state;
  ps2_state_e      state_nxt;
  logic [WD_W-1:0] wd;
  logic            emit;
  ps2_evt_t        evt;
  logic            err_proto;
  logic            err_timeout;
  logic            err_ovf;
  logic            full;
  logic            full_nxt;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    emit        = 1'b0;
    err_proto   = 1'b0;
    err_timeout = 1'b0;
    evt.code    = rx_dout;
    evt.ext     = (state == EXT) || (state == EXT_BRK);
    evt.brk     = (state == BRK) || (state == EXT_BRK);

    if (rx_done_tick) begin
      case (state)
        IDLE: begin
          if (rx_dout == PS2_PFX_EXT)      state_nxt = EXT;
          else if (rx_dout == PS2_PFX_BRK) state_nxt = BRK;
          else                             emit = 1'b1;
        end
        EXT: begin
          if (rx_dout == PS2_PFX_BRK) begin
            state_nxt = EXT_BRK;
          end else begin
            state_nxt = IDLE;
            if (rx_dout == PS2_PFX_EXT) err_proto = 1'b1;
            else                        emit      = 1'b1;
          end
        end
        BRK, EXT_BRK: begin
          state_nxt = IDLE;
          if (is_prefix(rx_dout)) err_proto = 1'b1;
          else                    emit      = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
      // A stalled prefix is abandoned; the receiver byte always wins over the watchdog.
      state_nxt   = IDLE;
      err_timeout = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      if (rx_done_tick || state_nxt == IDLE) wd <= '0;
      else                                   wd <= wd + 1'b1;
    end
  end

`ifdef PS2_KEY_FIFO_EN
  ps2_evt_t head;
  logic     empty;

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (emit),
    .pop      (key.key_ready),
    .din      (evt),
    .dout     (head),
    .empty    (empty),
    .full     (full),
    .full_nxt (full_nxt)
  );

  assign key.key_valid = !empty;
  assign key.key_code  = empty ? 8'h00 : head.code;
  assign key.key_ext   = !empty && head.ext;
  assign key.key_break = !empty && head.brk;
`else
  ps2_evt_t hold_evt;
  logic     hold_valid;
  logic     pop;
  logic     push_ok;

  assign pop     = hold_valid && key.key_ready;
  assign push_ok = emit && (!hold_valid || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_evt   <= '0;
    end else begin
      if (push_ok)  hold_evt <= evt;
      if (push_ok)  hold_valid <= 1'b1;
      else if (pop) hold_valid <= 1'b0;
    end
  end

  assign full     = hold_valid;
  assign full_nxt = push_ok || (hold_valid && !pop);

  assign key.key_valid = hold_valid;
  assign key.key_code  = hold_evt.code;
  assign key.key_ext   = hold_evt.ext;
  assign key.key_break = hold_evt.brk;
`endif

  // A full store only makes room in the same cycle if the consumer is popping.
  assign err_ovf = emit && full && !key.key_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_en    <= 1'b1;
      err_tick <= 1'b0;
    end else begin
      rx_en    <= !full_nxt;
      err_tick <= err_proto || err_timeout || err_ovf;
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed self-checking bench for ps2_key_ctrl (default or PS2_KEY_FIFO_EN build).
module tb_ps2_key_ctrl;

  localparam int TO    = 16;
  localparam int DEPTH = 4;
`ifdef PS2_KEY_FIFO_EN
  localparam int N = DEPTH;
`else
  localparam int N = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       rx_en;
  logic       err_tick;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_ctrl_if key_bus ();

  ps2_key_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rx_en        (rx_en),
    .err_tick     (err_tick),
    .key          (key_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dout      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_evt();
    key_bus.key_ready = 1'b1;
    @(negedge clk);
    key_bus.key_ready = 1'b0;
  endtask

  task automatic expect_evt(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    check({tag, ".valid"}, key_bus.key_valid, 1'b1);
    check({tag, ".code"},  key_bus.key_code,  code);
    check({tag, ".ext"},   key_bus.key_ext,   ext);
    check({tag, ".brk"},   key_bus.key_break, brk);
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, ".valid"}, key_bus.key_valid, 1'b0);
    check({tag, ".code"},  key_bus.key_code,  8'h00);
    check({tag, ".ext"},   key_bus.key_ext,   1'b0);
    check({tag, ".brk"},   key_bus.key_break, 1'b0);
    check({tag, ".err"},   err_tick,          1'b0);
    check({tag, ".rx_en"}, rx_en,             1'b1);
  endtask

  initial begin
    int         cnt;
    logic [7:0] exp_code;

    reset             = 1'b1;
    rx_done_tick      = 1'b0;
    rx_dout           = 8'h00;
    key_bus.key_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_reset_state("reset");

    // Plain make code with consumer ready: visible one cycle, then taken.
    key_bus.key_ready = 1'b1;
    send_byte(8'h1C);
    expect_evt("make_1c", 8'h1C, 1'b0, 1'b0);
    check("make_1c.err", err_tick, 1'b0);
    @(negedge clk);
    check("make_1c.popped", key_bus.key_valid, 1'b0);
    key_bus.key_ready = 1'b0;

    // Extended break: prefixes alone produce nothing.
    send_byte(8'hE0);
    check("e0.valid", key_bus.key_valid, 1'b0);
    send_byte(8'hF0);
    check("e0f0.valid", key_bus.key_valid, 1'b0);
    send_byte(8'h75);
    expect_evt("ext_brk_75", 8'h75, 1'b1, 1'b1);
    check("ext_brk_75.err", err_tick, 1'b0);
    pop_evt();

    // Watchdog: err_tick appears TO cycles after the E0 edge, as a single pulse.
    send_byte(8'hE0);
    check("to.err_early", err_tick, 1'b0);
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (err_tick) begin
        cnt = i;
        break;
      end
    end
    check("to.latency", cnt, TO);
    check("to.valid", key_bus.key_valid, 1'b0);
    @(negedge clk);
    check("to.single_pulse", err_tick, 1'b0);
    send_byte(8'h1C);
    expect_evt("to.next", 8'h1C, 1'b0, 1'b0);
    pop_evt();

    // Overflow: fill the store, the extra code is dropped with err_tick.
    for (int i = 0; i < N; i++) begin
      send_byte(8'h10 + 8'(i));
      check("fill.err", err_tick, 1'b0);
      check("fill.rx_en", rx_en, (i == N - 1) ? 1'b0 : 1'b1);
    end
    send_byte(8'h2A);
    check("ovf.err", err_tick, 1'b1);
    check("ovf.rx_en", rx_en, 1'b0);
    @(negedge clk);
    check("ovf.single_pulse", err_tick, 1'b0);
    for (int i = 0; i < N; i++) begin
      exp_code = 8'h10 + 8'(i);
      expect_evt("drain", exp_code, 1'b0, 1'b0);
      pop_evt();
    end
    check("drain.empty", key_bus.key_valid, 1'b0);
    check("drain.rx_en", rx_en, 1'b1);

    // Push and pop together on a full store: both accepted, no error.
    for (int i = 0; i < N; i++) send_byte(8'h10 + 8'(i));
    @(negedge clk);
    key_bus.key_ready = 1'b1;
    rx_dout           = 8'h3B;
    rx_done_tick      = 1'b1;
    @(negedge clk);
    key_bus.key_ready = 1'b0;
    rx_done_tick      = 1'b0;
    check("pushpop.err", err_tick, 1'b0);
    check("pushpop.rx_en", rx_en, 1'b0);
    for (int i = 1; i < N; i++) begin
      exp_code = 8'h10 + 8'(i);
      expect_evt("pushpop.drain", exp_code, 1'b0, 1'b0);
      pop_evt();
    end
    expect_evt("pushpop.last", 8'h3B, 1'b0, 1'b0);
    pop_evt();
    check("pushpop.empty", key_bus.key_valid, 1'b0);

    // Double break prefix is a protocol error; decoder recovers on the next byte.
    send_byte(8'hF0);
    check("f0f0.first_err", err_tick, 1'b0);
    send_byte(8'hF0);
    check("f0f0.err", err_tick, 1'b1);
    check("f0f0.valid", key_bus.key_valid, 1'b0);
    send_byte(8'h32);
    expect_evt("f0f0.next", 8'h32, 1'b0, 1'b0);
    check("f0f0.next_err", err_tick, 1'b0);
    pop_evt();

    // Reset mid-prefix, with a byte landing in the reset cycle.
    send_byte(8'hE0);
    @(negedge clk);
    reset        = 1'b1;
    rx_dout      = 8'h1C;
    rx_done_tick = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    expect_reset_state("rst_pfx");
    send_byte(8'h1C);
    expect_evt("rst_pfx.next", 8'h1C, 1'b0, 1'b0);
    pop_evt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000, prefix-to-code watchdog in clk cycles (20 ms at 100 MHz).
REQ-002 Parameter FIFO_DEPTH, default 4, event FIFO depth (power of two, 2..16); used only when PS2_KEY_FIFO_EN is defined.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_done_tick  in  1  one-cycle pulse from the PS/2 receiver; byte valid on rx_dout.
REQ-006 rx_dout  in  8  received byte.
REQ-007 rx_en  out  1  receiver enable; gates the start of a new frame.
REQ-008 key_valid  out  1  key event available.
REQ-009 key_ready  in  1  consumer accepts the event when key_valid & key_ready.
REQ-010 key_code  out  8  scan code, excluding prefixes.
REQ-011 key_ext  out  1  code was preceded by E0.
REQ-012 key_break  out  1  release event (code was preceded by F0).
REQ-013 err_tick  out  1  one-cycle pulse on protocol error, timeout or overflow.

Function
REQ-014 The FSM SHALL have states IDLE, EXT, BRK and EXT_BRK, updated on posedge clk only.
REQ-015 Bytes SHALL be consumed only in a cycle with rx_done_tick=1.
REQ-016 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> emit {code, ext=0, brk=0}, stay in IDLE.
REQ-017 EXT: F0 -> EXT_BRK; E0 -> error, go to IDLE; other -> emit {code, 1, 0}, go to IDLE.
REQ-018 BRK: E0 or F0 -> error, go to IDLE; other -> emit {code, 0, 1}, go to IDLE.
REQ-019 EXT_BRK: E0 or F0 -> error, go to IDLE; other -> emit {code, 1, 1}, go to IDLE.
REQ-020 A watchdog counter SHALL clear on every rx_done_tick and on entry to IDLE, and increment while not in IDLE.
REQ-021 When the watchdog reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM SHALL go to IDLE and pulse err_tick; the partial prefix is discarded.
REQ-022 An emit SHALL make the event visible on key_* one cycle after the rx_done_tick cycle.
REQ-023 An emit while the event store is full and not being popped in the same cycle SHALL drop the new event and pulse err_tick.
REQ-024 A simultaneous push and pop on a full store SHALL accept both with no error.
REQ-025 rx_en SHALL be 0 while the event store is full, otherwise 1 (registered output).
REQ-026 key_code, key_ext and key_break SHALL hold stable while key_valid=1 and key_ready=0.
REQ-027 err_tick SHALL pulse exactly once per error cycle; simultaneous causes SHALL produce one pulse.

Reset
REQ-028 On reset: FSM=IDLE, watchdog=0, store empty, key_valid=0, key_code=0, key_ext=0, key_break=0, err_tick=0, rx_en=1.
REQ-029 A reset during any prefix state SHALL discard the prefix; a byte arriving in the reset cycle SHALL be ignored.

Configuration
REQ-030 PS2_KEY_FIFO_EN defined: the event store is a FIFO of FIFO_DEPTH 10-bit entries {ext, brk, code}; output shows the head entry (first-word fall-through).
REQ-031 PS2_KEY_FIFO_EN undefined: the event store is a single holding register; full = key_valid; FIFO_DEPTH is ignored.

Structure
REQ-032 Package ps2_pkg SHALL hold the FSM state enum, PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, and the 10-bit event typedef.
REQ-033 Sub-module ps2_evt_fifo (synchronous FIFO with full/empty, push, pop) SHALL be instantiated only under PS2_KEY_FIFO_EN.

Verification
REQ-034 Bytes 1C with key_ready=1 -> one event {1C, ext=0, brk=0}; no err_tick.
REQ-035 Bytes E0, F0, 75 -> one event {75, ext=1, brk=1}; no events for the prefixes.
REQ-036 Byte E0, then no byte for TIMEOUT_CYCLES -> err_tick pulse at that cycle; FSM=IDLE; next byte 1C -> {1C, 0, 0}.
REQ-037 key_ready=0, send FIFO_DEPTH+1 codes (1 in non-FIFO build) -> rx_en=0 once full, last code dropped with err_tick; draining returns codes in order.
REQ-038 Bytes F0, F0 -> err_tick on the second byte; next byte 32 -> {32, 0, 0}.
REQ-039 Reset asserted after E0 -> all outputs at reset values; next byte 1C -> {1C, 0, 0}.
